// File: rtl/pump_scheduler.sv
// Moore scheduler sharing fill pumps B0/B1 between low/high level sensor requests,
// with lead alternation, boost on long fills, minimum on-time and fault routing.
module pump_scheduler #(
  parameter int unsigned MIN_ON = 4,
  parameter int unsigned BOOST  = 8,
  parameter int unsigned CW     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_i,
  input  logic       sensor_s,
  input  logic       fault0,
  input  logic       fault1,
  input  logic       clear,
  output logic       b0,
  output logic       b1,
  output logic       alarm,
  output logic       lead,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL_ONE  = 2'd1,
    FILL_BOTH = 2'd2,
    ALARM     = 2'd3
  } stateT;

  localparam logic [CW-1:0] MinOnLast = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] BoostLast = CW'(BOOST - 1);

  stateT         curState, nxtState;
  logic [CW-1:0] runCnt;
  logic          act, nxtAct;
  logic          leadReg, nxtLead;
  logic          clrCnt;

  logic sensorErr, dblFault, faultAct, faultOther, leadFault, minOnMet;

  assign sensorErr  = sensor_s & ~sensor_i;
  assign dblFault   = fault0 & fault1;
  assign faultAct   = act ? fault1 : fault0;
  assign faultOther = act ? fault0 : fault1;
  assign leadFault  = leadReg ? fault1 : fault0;
  assign minOnMet   = (runCnt >= MinOnLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      curState <= IDLE;
      runCnt   <= '0;
      act      <= 1'b0;
      leadReg  <= 1'b0;
    end else begin
      curState <= nxtState;
      act      <= nxtAct;
      leadReg  <= nxtLead;
      if (clrCnt)
        runCnt <= '0;
      else if (runCnt != '1)
        runCnt <= runCnt + CW'(1);
    end
  end

  always_comb begin
    nxtState = curState;
    nxtAct   = act;
    nxtLead  = leadReg;
    clrCnt   = 1'b0;
    if (curState != ALARM && (sensorErr || dblFault)) begin
      nxtState = ALARM;
    end else begin
      unique case (curState)
        IDLE: begin
          if (!sensor_i) begin
            nxtState = FILL_ONE;
            nxtAct   = leadFault ? ~leadReg : leadReg;
            clrCnt   = 1'b1;
          end
        end
        FILL_ONE: begin
          // fault switch takes precedence over a stop request at the same edge
          if (faultAct) begin
            nxtAct = ~act;
            clrCnt = 1'b1;
          end else if (sensor_s && minOnMet) begin
            nxtState = IDLE;
            nxtLead  = ~act;
          end else if (!sensor_i && runCnt >= BoostLast && !faultOther) begin
            nxtState = FILL_BOTH;
            clrCnt   = 1'b1;
          end
        end
        FILL_BOTH: begin
          if (fault0 ^ fault1) begin
            nxtState = FILL_ONE;
            nxtAct   = fault0;
            clrCnt   = 1'b1;
          end else if (sensor_s && minOnMet) begin
            nxtState = IDLE;
            nxtLead  = ~leadReg;
          end
        end
        ALARM: begin
          if (clear && !sensorErr && !dblFault)
            nxtState = IDLE;
        end
        default: nxtState = IDLE;
      endcase
    end
  end

  assign b0    = (curState == FILL_BOTH) | ((curState == FILL_ONE) & ~act);
  assign b1    = (curState == FILL_BOTH) | ((curState == FILL_ONE) & act);
  assign alarm = (curState == ALARM);
  assign lead  = leadReg;
  assign state = curState;

endmodule

// File: tb/tb_pump_scheduler.sv
// Directed bench for pump_scheduler: each step queues the expected post-edge
// outputs, then pops and checks them one time unit after the rising edge.
module tb_pump_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_i = 1'b1;
  logic       sensor_s = 1'b0;
  logic       fault0 = 1'b0;
  logic       fault1 = 1'b0;
  logic       clear = 1'b0;
  logic       b0, b1, alarm, lead;
  logic [1:0] state;

  int unsigned testsRun = 0;
  int unsigned testsFailed = 0;

  typedef struct {
    logic [5:0] outs;
    string      tag;
  } expT;

  expT expQ[$];

  pump_scheduler #(.MIN_ON(4), .BOOST(8), .CW(8)) dut (
    .clk(clk), .reset(reset), .sensor_i(sensor_i), .sensor_s(sensor_s),
    .fault0(fault0), .fault1(fault1), .clear(clear),
    .b0(b0), .b1(b1), .alarm(alarm), .lead(lead), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOut();
    expT e;
    logic [5:0] obs;
    e = expQ.pop_front();
    obs = {state, b0, b1, alarm, lead};
    testsRun++;
    assert (obs === e.outs) else begin
      testsFailed++;
      $error("FAIL %s: observed {state,b0,b1,alarm,lead}=%b expected %b", e.tag, obs, e.outs);
    end
  endtask

  // inVec = {reset, sensor_i, sensor_s, fault0, fault1, clear}; eb = {b0, b1, lead}
  task automatic step(input logic [5:0] inVec, input logic [1:0] es,
                      input logic [2:0] eb, input string tag);
    expT e;
    @(negedge clk);
    {reset, sensor_i, sensor_s, fault0, fault1, clear} = inVec;
    e.outs = {es, eb[2], eb[1], (es == 2'd3), eb[0]};
    e.tag  = tag;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOut();
  endtask

  initial begin
    // reset and first fill on B0, stop after exactly MIN_ON cycles
    step(6'b110000, 2'd0, 3'b000, "reset");
    step(6'b000000, 2'd1, 3'b100, "fill1_start");
    for (int k = 0; k < 3; k++) step(6'b000000, 2'd1, 3'b100, "fill1_hold");
    step(6'b011000, 2'd0, 3'b001, "fill1_stop");

    // sensor error alarm, clear rules, lead preserved
    step(6'b001000, 2'd3, 3'b001, "sens_err");
    step(6'b001001, 2'd3, 3'b001, "clr_bad_sens");
    step(6'b011000, 2'd3, 3'b001, "alarm_no_clear");
    step(6'b011001, 2'd0, 3'b001, "alarm_clr_ok");

    // second fill on B1, boost after BOOST cycles, stop after MIN_ON in FILL_BOTH
    step(6'b000000, 2'd1, 3'b011, "fill2_b1");
    for (int k = 0; k < 7; k++) step(6'b000000, 2'd1, 3'b011, "fill2_hold");
    step(6'b000000, 2'd2, 3'b111, "boost");
    for (int k = 0; k < 3; k++) step(6'b011000, 2'd2, 3'b111, "both_min_on");
    step(6'b011000, 2'd0, 3'b000, "both_stop");

    // fault switch, double fault alarm, clear only with a healthy pump
    step(6'b000000, 2'd1, 3'b100, "fill3_b0");
    step(6'b000100, 2'd1, 3'b010, "f0_switch");
    step(6'b000110, 2'd3, 3'b000, "dbl_fault");
    step(6'b000111, 2'd3, 3'b000, "clr_no_pump");
    step(6'b000101, 2'd0, 3'b000, "clr_one_pump");

    // faulted lead at fill start, boost blocked by faulted other pump
    step(6'b000100, 2'd1, 3'b010, "idle_lead_faulted");
    for (int k = 0; k < 8; k++) step(6'b000100, 2'd1, 3'b010, "boost_blocked");
    step(6'b011100, 2'd0, 3'b000, "fill4_stop");

    // single fault in FILL_BOTH drops to FILL_ONE on the healthy pump
    step(6'b000000, 2'd1, 3'b100, "fill5");
    for (int k = 0; k < 7; k++) step(6'b000000, 2'd1, 3'b100, "fill5_hold");
    step(6'b000000, 2'd2, 3'b110, "boost2");
    step(6'b000100, 2'd1, 3'b010, "both_f0");
    for (int k = 0; k < 3; k++) step(6'b011000, 2'd1, 3'b010, "after_fault_min_on");
    step(6'b011000, 2'd0, 3'b000, "fill5_stop");

    // S rise together with active-pump fault: fault wins
    step(6'b000000, 2'd1, 3'b100, "fill6");
    for (int k = 0; k < 3; k++) step(6'b000000, 2'd1, 3'b100, "fill6_hold");
    step(6'b011100, 2'd1, 3'b010, "s_vs_fault");
    for (int k = 0; k < 3; k++) step(6'b011000, 2'd1, 3'b010, "s_vs_fault_min_on");
    step(6'b011000, 2'd0, 3'b000, "fill6_stop");

    // S=1 from the first fill cycle: pump held for MIN_ON cycles
    step(6'b000000, 2'd1, 3'b100, "fill7");
    for (int k = 0; k < 3; k++) step(6'b011000, 2'd1, 3'b100, "early_s_hold");
    step(6'b011000, 2'd0, 3'b001, "early_s_stop");

    // reset in the middle of FILL_BOTH
    step(6'b000000, 2'd1, 3'b011, "fill8");
    for (int k = 0; k < 7; k++) step(6'b000000, 2'd1, 3'b011, "fill8_hold");
    step(6'b000000, 2'd2, 3'b111, "boost3");
    step(6'b100000, 2'd0, 3'b000, "mid_reset");
    step(6'b010000, 2'd0, 3'b000, "post_reset");
    step(6'b010001, 2'd0, 3'b000, "clr_ignored_idle");

    testsRun++;
    assert (expQ.size() == 0) else begin
      testsFailed++;
      $error("FAIL queue_drain: observed %0d pending expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
